wrb_scheduler: RTL and testbench

WRB_SCHEDULER -- requirements
Module: wrb_scheduler

---
 rtl/wrb_scheduler_pkg.sv | 45 ++++
 rtl/wrb_scheduler_rr_arbiter.sv | 32 +++
 rtl/wrb_scheduler.sv | 141 ++++++++++++++
 tb/tb_wrb_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wrb_scheduler_pkg.sv
// Shared types and default widths for the write-back scheduler and its
// packet consumer (the write-back decoder).
package wrb_scheduler_pkg;

  localparam int CNN_XLEN   = 16;
  localparam int ICP_NUM_D  = 2;
  localparam int OCP_NUM_D  = 4;
  localparam int ADDR_B_D   = 4;
  localparam int ICP_B_D    = $clog2(ICP_NUM_D);
  localparam int OCP_B_D    = $clog2(OCP_NUM_D);
  localparam int WRB_ADDR_W = ADDR_B_D + ICP_B_D + OCP_B_D;

  typedef enum logic [2:0] {
    INVALID = 3'd0,
    PE_LOAD = 3'd1,
    PE_CONV = 3'd2,
    PE_POOL = 3'd3,
    PE_WRB  = 3'd4
  } PE_STATE_T;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } sched_state_t;

  typedef struct packed {
    PE_STATE_T               PE_state;
    logic                    wrb;
    logic [CNN_XLEN-1:0]     wrb_data;
    logic [WRB_ADDR_W-1:0]   wrb_addr;
    logic [ADDR_B_D-1:0]     rdb_addr;
  } CNTR_PACKET;

  // Write-back address layout: {channel, bank, word offset}.
  function automatic logic [WRB_ADDR_W-1:0] pack_addr(
    input logic [OCP_B_D-1:0]  ch,
    input logic [ICP_B_D-1:0]  bank,
    input logic [ADDR_B_D-1:0] off
  );
    return {ch, bank, off};
  endfunction

endpackage

// File: rtl/wrb_scheduler_rr_arbiter.sv
// Round-robin priority picker: grants the first requester at or above the
// pointer, wrapping to the low indices.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int PB = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PB-1:0] i_ptr,
  output logic [N-1:0]  o_gnt
);

  logic w_found;

  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    for (int j = 0; j < N; j++) begin
      if (!w_found && (j >= int'(i_ptr)) && i_req[j]) begin
        o_gnt[j] = 1'b1;
        w_found  = 1'b1;
      end
    end
    // Wrapped pass over the indices below the pointer.
    for (int j = 0; j < N; j++) begin
      if (!w_found && (j < int'(i_ptr)) && i_req[j]) begin
        o_gnt[j] = 1'b1;
        w_found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wrb_scheduler.sv
// Layer write-back scheduler: round-robin grants OCP_NUM channel requesters and
// emits one registered write packet per handshake, addressed {channel, bank, offset}.
module wrb_scheduler
  import wrb_scheduler_pkg::*;
#(
  parameter int DATA_WID = CNN_XLEN,
  parameter int ICP_NUM  = ICP_NUM_D,
  parameter int OCP_NUM  = OCP_NUM_D,
  parameter int ADDR_B   = ADDR_B_D
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        start,
  input  logic [ADDR_B:0]             frame_len,
  input  PE_STATE_T                   pe_state_in,
  input  logic [ADDR_B-1:0]           rdb_addr_in,
  input  logic [OCP_NUM-1:0]          req_valid,
  input  logic [OCP_NUM*DATA_WID-1:0] req_data,
  output logic [OCP_NUM-1:0]          req_ready,
  output CNTR_PACKET                  cntr_pk_out,
  output logic                        busy,
  output logic                        done
);

  localparam int ICP_B = $clog2(ICP_NUM);
  localparam int OCP_B = $clog2(OCP_NUM);

  sched_state_t        r_state, w_nstate;
  logic [ADDR_B:0]     r_frame_len;
  logic [ADDR_B-1:0]   r_off [OCP_NUM];
  logic [ICP_B-1:0]    r_icp [OCP_NUM];
  logic [OCP_NUM-1:0]  r_fin;
  logic [OCP_B-1:0]    r_rr;
  CNTR_PACKET          r_pk;

  logic [OCP_NUM-1:0]  w_req, w_gnt;
  logic                w_hs, w_accept;
  logic [OCP_B-1:0]    w_idx;
  logic [ADDR_B-1:0]   w_off_sel;
  logic [ICP_B-1:0]    w_icp_sel;
  logic [DATA_WID-1:0] w_data_sel;

  assign w_accept = (r_state == S_IDLE) && start;
  // Finished channels are masked so a lingering valid can never be granted.
  assign w_req    = (r_state == S_RUN) ? (req_valid & ~r_fin) : '0;

  rr_arbiter #(
    .N  (OCP_NUM),
    .PB (OCP_B)
  ) u_arb (
    .i_req (w_req),
    .i_ptr (r_rr),
    .o_gnt (w_gnt)
  );

  assign req_ready = w_gnt;
  assign w_hs      = |w_gnt;

  always_comb begin
    w_idx      = '0;
    w_off_sel  = '0;
    w_icp_sel  = '0;
    w_data_sel = '0;
    for (int r = 0; r < OCP_NUM; r++) begin
      if (w_gnt[r]) begin
        w_idx      = OCP_B'(r);
        w_off_sel  = r_off[r];
        w_icp_sel  = r_icp[r];
        w_data_sel = req_data[r*DATA_WID +: DATA_WID];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nstate;
    end
  end

  always_comb begin
    w_nstate = r_state;
    case (r_state)
      S_IDLE:  if (start) w_nstate = (frame_len != '0) ? S_RUN : S_DONE;
      S_RUN:   if (&r_fin) w_nstate = S_DRAIN;
      S_DRAIN: w_nstate = S_DONE;
      S_DONE:  w_nstate = S_IDLE;
      default: w_nstate = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int r = 0; r < OCP_NUM; r++) begin
        r_off[r] <= '0;
        r_icp[r] <= '0;
      end
      r_fin       <= '0;
      r_rr        <= '0;
      r_frame_len <= '0;
    end else if (w_accept) begin
      for (int r = 0; r < OCP_NUM; r++) begin
        r_off[r] <= '0;
        r_icp[r] <= '0;
      end
      r_fin       <= '0;
      r_rr        <= '0;
      r_frame_len <= frame_len;
    end else if (w_hs) begin
      r_rr <= (w_idx == OCP_B'(OCP_NUM-1)) ? '0 : w_idx + OCP_B'(1);
      if ({1'b0, w_off_sel} == r_frame_len - 1'b1) begin
        r_off[w_idx] <= '0;
        r_icp[w_idx] <= (w_icp_sel == ICP_B'(ICP_NUM-1)) ? '0 : w_icp_sel + ICP_B'(1);
        if (w_icp_sel == ICP_B'(ICP_NUM-1)) r_fin[w_idx] <= 1'b1;
      end else begin
        r_off[w_idx] <= w_off_sel + ADDR_B'(1);
      end
    end
  end

  // Output packet stage: addresses carry the pre-increment counter values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pk <= '0;
    end else begin
      r_pk.wrb <= w_hs;
      if (w_hs) begin
        r_pk.wrb_data <= CNN_XLEN'(w_data_sel);
        r_pk.wrb_addr <= pack_addr(w_idx, w_icp_sel, w_off_sel);
      end
      r_pk.PE_state <= (r_state == S_RUN || r_state == S_DRAIN) ? pe_state_in : INVALID;
      r_pk.rdb_addr <= rdb_addr_in;
    end
  end

  assign cntr_pk_out = r_pk;
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);

endmodule

// File: tb/tb_wrb_scheduler.sv
// Bench for wrb_scheduler: directed and random layers checked against a
// per-channel write-count model and an address scoreboard.
module tb_wrb_scheduler;
  import wrb_scheduler_pkg::*;

  localparam int OCP = 4;
  localparam int ICP = 2;
  localparam int AB  = 4;
  localparam int DW  = 16;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [AB:0]       frame_len;
  PE_STATE_T         pe_state_in;
  logic [AB-1:0]     rdb_addr_in;
  logic [OCP-1:0]    req_valid;
  logic [OCP*DW-1:0] req_data;
  logic [OCP-1:0]    req_ready;
  CNTR_PACKET        cntr_pk_out;
  logic              busy;
  logic              done;

  wrb_scheduler #(.DATA_WID(DW), .ICP_NUM(ICP), .OCP_NUM(OCP), .ADDR_B(AB)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .start       (start),
    .frame_len   (frame_len),
    .pe_state_in (pe_state_in),
    .rdb_addr_in (rdb_addr_in),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .cntr_pk_out (cntr_pk_out),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: writes completed per channel, RR pointer, active layer length.
  int n_wr[OCP];
  int ptr;
  int flen;
  bit active;
  int seen[128];
  int wrb_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [OCP-1:0] model_gnt(input logic [OCP-1:0] v);
    logic [OCP-1:0] g;
    g = '0;
    if (active) begin
      for (int i = 0; i < OCP; i++) begin
        int c;
        c = (ptr + i) % OCP;
        if (g == '0 && v[c] && n_wr[c] < ICP * flen) g[c] = 1'b1;
      end
    end
    return g;
  endfunction

  // One clock cycle: randomize data, check grant at negedge, check packet after posedge.
  task automatic step();
    logic [OCP-1:0] eg;
    logic [DW-1:0]  ed;
    logic [AB-1:0]  er;
    int             ch;
    int             ea;
    req_data    = {$urandom, $urandom};
    rdb_addr_in = AB'($urandom);
    er = rdb_addr_in;
    ed = '0;
    ea = 0;
    @(negedge clk);
    eg = model_gnt(req_valid);
    chk("req_ready", 64'(req_ready), 64'(eg));
    ch = -1;
    for (int i = 0; i < OCP; i++) if (eg[i]) ch = i;
    if (ch >= 0) begin
      ed = req_data[ch*DW +: DW];
      ea = ch * 32 + (n_wr[ch] / flen) * 16 + (n_wr[ch] % flen);
    end
    @(posedge clk);
    #1;
    chk("wrb", 64'(cntr_pk_out.wrb), 64'(ch >= 0));
    chk("rdb_addr", 64'(cntr_pk_out.rdb_addr), 64'(er));
    if (ch >= 0) begin
      chk("wrb_addr", 64'(cntr_pk_out.wrb_addr), 64'(ea));
      chk("wrb_data", 64'(cntr_pk_out.wrb_data), 64'(ed));
      n_wr[ch]++;
      ptr = (ch + 1) % OCP;
    end
    if (cntr_pk_out.wrb) begin
      seen[cntr_pk_out.wrb_addr]++;
      wrb_cnt++;
    end
  endtask

  task automatic do_start(input int len, input bit accept);
    start     = 1'b1;
    frame_len = (AB+1)'(len);
    step();
    start = 1'b0;
    if (accept) begin
      flen    = len;
      n_wr    = '{default: 0};
      ptr     = 0;
      active  = (len != 0);
      wrb_cnt = 0;
      seen    = '{default: 0};
    end
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    bit got;
    int tot;
    got = 1'b0;
    for (int k = 0; k < budget && !got; k++) begin
      if (rnd) req_valid = OCP'($urandom);
      step();
      if (done) got = 1'b1;
    end
    chk("done_seen", 64'(got), 64'(1));
    if (got) begin
      tot = 0;
      for (int i = 0; i < OCP; i++) tot += n_wr[i];
      chk("writes_before_done", 64'(tot), 64'(OCP * ICP * flen));
      chk("busy_in_done", 64'(busy), 64'(1));
      step();
      chk("done_one_cycle", 64'(done), 64'(0));
      chk("busy_after_done", 64'(busy), 64'(0));
      chk("pe_state_idle", 64'(cntr_pk_out.PE_state), 64'(INVALID));
    end
    active = 1'b0;
  endtask

  task automatic end_run();
    int bad;
    int e;
    bad = 0;
    for (int a = 0; a < 128; a++) begin
      e = ((a >> 5) < OCP && (a & 15) < flen) ? 1 : 0;
      if (seen[a] != e) bad++;
    end
    chk("wrb_total", 64'(wrb_cnt), 64'(OCP * ICP * flen));
    chk("scoreboard_exact_once", 64'(bad), 64'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    reset_n     = 1'b0;
    start       = 1'b0;
    frame_len   = '0;
    pe_state_in = PE_CONV;
    rdb_addr_in = '0;
    req_valid   = '0;
    req_data    = '0;
    n_wr        = '{default: 0};
    ptr         = 0;
    flen        = 1;
    active      = 1'b0;
    seen        = '{default: 0};
    wrb_cnt     = 0;
    #1;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_ready", 64'(req_ready), 64'(0));
    chk("rst_packet", 64'(cntr_pk_out), 64'(0));
    #21;
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // All channels valid, frame_len=3: strict 0,1,2,3 rotation, 24 writes.
    req_valid = '1;
    do_start(3, 1'b1);
    chk("busy_after_start", 64'(busy), 64'(1));
    for (int k = 0; k < 3; k++) step();
    chk("pe_state_run", 64'(cntr_pk_out.PE_state), 64'(PE_CONV));
    wait_done(100, 1'b0);
    end_run();

    // Only ch2 valid, frame_len=2: 0x40,0x41,0x50,0x51 back to back, then blocked.
    req_valid = 4'b0100;
    do_start(2, 1'b1);
    for (int k = 0; k < 6; k++) step();
    chk("ch2_finished_ready", 64'(req_ready[2]), 64'(0));
    chk("no_done_while_others", 64'(done), 64'(0));
    chk("ch2_writes", 64'(wrb_cnt), 64'(4));
    req_valid = '1;
    wait_done(100, 1'b0);
    end_run();

    // Zero-length layer: straight to a done pulse with no writes.
    do_start(0, 1'b1);
    chk("zero_len_busy", 64'(busy), 64'(1));
    chk("zero_len_done", 64'(done), 64'(1));
    step();
    chk("zero_len_done_end", 64'(done), 64'(0));
    chk("zero_len_busy_end", 64'(busy), 64'(0));
    chk("zero_len_no_wrb", 64'(wrb_cnt), 64'(0));

    // Reset after 5 handshakes: outputs clear immediately, no writes until restart.
    req_valid = '1;
    do_start(3, 1'b1);
    for (int k = 0; k < 5; k++) step();
    chk("five_handshakes", 64'(wrb_cnt), 64'(5));
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(req_ready), 64'(0));
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_done", 64'(done), 64'(0));
    chk("mid_rst_packet", 64'(cntr_pk_out), 64'(0));
    active = 1'b0;
    #9;
    reset_n = 1'b1;
    #8;
    wrb_cnt = 0;
    for (int k = 0; k < 3; k++) step();
    chk("no_wrb_after_reset", 64'(wrb_cnt), 64'(0));
    do_start(3, 1'b1);
    wait_done(100, 1'b0);
    end_run();

    // Start during RUN with a different length is ignored.
    do_start(3, 1'b1);
    for (int k = 0; k < 4; k++) step();
    do_start(7, 1'b0);
    frame_len = 5'd9;
    wait_done(100, 1'b0);
    end_run();

    // Random valid toggling over several layers.
    for (int run = 0; run < 4; run++) begin
      req_valid = OCP'($urandom);
      do_start(int'($urandom_range(1, 5)), 1'b1);
      wait_done(800, 1'b1);
      end_run();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
